// File: rtl/sum16bit_arbiter.sv
// sum16bit_arbiter: shares one sum16bit adder between NREQ valid/ready requesters.
// Define SUM16_ARB_RR_EN for round-robin grants; otherwise lowest index wins.

module sum16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [1:0]  i_kin,
  output logic [16:0] o_sum
);
  logic w_cin;

  // Only the generate code (2'b11) injects a carry; kill (2'b00) and the rest inject none.
  assign w_cin = i_kin[1] & i_kin[0];
  assign o_sum = {1'b0, i_a} + {1'b0, i_b} + {16'b0, w_cin};
endmodule

module sum16bit_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16:0]          rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     w_a_arr [NREQ];
  logic [15:0]     w_b_arr [NREQ];
  logic [15:0]     r_a;
  logic [15:0]     r_b;
  logic            r_cin;
  logic [ID_W-1:0] r_id;
  logic [16:0]     r_sum;
  logic            w_any;
  logic            w_accept;
  logic            w_take;
  logic [ID_W-1:0] w_grant;
  logic [1:0]      w_kin;
  logic [16:0]     w_sum;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[16*gi +: 16];
      assign w_b_arr[gi] = req_b[16*gi +: 16];
    end
  endgenerate

  // Reset gates the accept window so req_ready drops the moment rst rises.
  assign w_any    = |req_valid;
  assign w_accept = ~rst & ((r_state == IDLE) | ((r_state == RESP) & rsp_ready));
  assign w_take   = w_accept & w_any;

`ifdef SUM16_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;

  always_comb begin
    logic [ID_W:0] v_idx;
    logic          v_found;
    w_grant = '0;
    v_found = 1'b0;
    v_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v_idx >= (ID_W+1)'(NREQ)) begin
        v_idx = v_idx - (ID_W+1)'(NREQ);
      end
      if (!v_found && req_valid[v_idx[ID_W-1:0]]) begin
        w_grant = v_idx[ID_W-1:0];
        v_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_grant == ID_W'(NREQ-1)) ? '0 : w_grant + ID_W'(1);
    end
  end
`else
  always_comb begin
    w_grant = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_grant = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (w_take) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_next = CALC;
      CALC:    w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = w_take ? CALC : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_id  <= '0;
      r_sum <= '0;
    end else begin
      if (w_take) begin
        r_a   <= w_a_arr[w_grant];
        r_b   <= w_b_arr[w_grant];
        r_cin <= req_cin[w_grant];
        r_id  <= w_grant;
      end
      if (r_state == CALC) begin
        r_sum <= w_sum;
      end
    end
  end

  // Carry-in travels to the adder as generate/kill, asserted only while computing.
  assign w_kin = ((r_state == CALC) && r_cin) ? 2'b11 : 2'b00;

  sum16bit u_sum16bit (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_kin (w_kin),
    .o_sum (w_sum)
  );

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
endmodule

// File: tb/tb_sum16bit_arbiter.sv
// Scoreboard bench for sum16bit_arbiter: directed scenarios followed by random traffic.
`timescale 1ns/1ps

module tb_sum16bit_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
`ifdef SUM16_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_a;
  logic [16*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_cin;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [16:0]         rsp_sum;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;

  sum16bit_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] sum;
    int          id;
    logic        cin;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic m_busy   = 1'b0;
  int   m_age    = 0;
  int   m_ptr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester search from a start index, wrapping; -1 when nobody is valid.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (start + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor / scoreboard: evaluates the model at each falling edge.
  always @(negedge clk) begin
    logic        exp_rv;
    logic        window;
    int          g;
    logic [3:0]  exp_ready;
    logic [16:0] es;
    exp_t        e;
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      m_age  = 0;
      m_ptr  = 0;
    end else begin
      exp_rv = m_busy && (m_age >= 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_busy && m_age == 1 && q.size() > 0) begin
        chk("kin", 32'(dut.w_kin), q[0].cin ? 32'd3 : 32'd0);
      end
      window    = !m_busy || (exp_rv && rsp_ready);
      g         = window ? model_grant(req_valid, RR ? m_ptr : 0) : -1;
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          $display("rsp id=%0d sum=%05h expect id=%0d sum=%05h", rsp_id, rsp_sum, e.id, e.sum);
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
      if (g >= 0) begin
        es = {1'b0, req_a[16*g +: 16]} + {1'b0, req_b[16*g +: 16]} + {16'b0, req_cin[g]};
        e.sum = es;
        e.id  = g;
        e.cin = req_cin[g];
        q.push_back(e);
        if (RR) m_ptr = (g + 1) % NREQ;
        m_busy = 1'b1;
        m_age  = 1;
      end else if (window) begin
        m_busy = 1'b0;
        m_age  = 0;
      end else if (m_busy && m_age < 100) begin
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = c;
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int n);
    tick();
    set_op(i, a, b, c);
    req_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 50);
    chk("issue_handshake", 32'(req_ready[i]), 32'd1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int m);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!rsp_valid && m < 10);
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom % 4)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int gid[$];
    int gcyc[$];
    int cyc;
    int exp_seq[5];
    logic [NREQ-1:0] hs;

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    rst       = 1'b0;

    // All four requesters continuously valid, consumer always ready.
    tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(16'h1000 * i + 16'h0011), 16'(16'h0100 * i), 1'(i % 2));
    req_valid = '1;
    for (cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          gid.push_back(i);
          gcyc.push_back(cyc);
        end
      end
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) exp_seq[k] = RR ? (k % NREQ) : 0;
    chk("rr_grant_count", 32'(gid.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < gid.size(); k++) begin
      chk("grant_order", 32'(gid[k]), 32'(exp_seq[k]));
      if (k > 0) chk("grant_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
    end
    repeat (4) tick();

    // Single requester 2, carry-out case.
    issue(2, 16'h9999, 16'hFFFF, 1'b0, n);
    chk("t1_accept_cycles", 32'(n), 32'd1);
    wait_rsp(m);
    chk("t1_latency", 32'(m), 32'd2);
    chk("t1_sum", 32'(rsp_sum), 32'h19998);
    chk("t1_id", 32'(rsp_id), 32'd2);

    // Carry-in generate then kill.
    issue(0, 16'hFFFF, 16'h0000, 1'b1, n);
    @(negedge clk);
    chk("t2_kin_gen", 32'(dut.w_kin), 32'd3);
    wait_rsp(m);
    chk("t2_sum_a", 32'(rsp_sum), 32'h10000);
    issue(0, 16'h0001, 16'h0001, 1'b0, n);
    @(negedge clk);
    chk("t2_kin_kill", 32'(dut.w_kin), 32'd0);
    wait_rsp(m);
    chk("t2_sum_b", 32'(rsp_sum), 32'h00002);

    // Backpressure: result held, a 1-cycle req_valid[1] pulse in RESP is ignored.
    tick();
    rsp_ready = 1'b0;
    issue(3, 16'h1234, 16'hABCD, 1'b1, n);
    set_op(2, 16'h0F0F, 16'h00F1, 1'b0);
    req_valid[2] = 1'b1;
    wait_rsp(m);
    for (int h = 0; h < 5; h++) begin
      tick();
      if (h == 1) set_op(1, 16'h7777, 16'h1111, 1'b1);
      req_valid[1] = (h == 1);
      @(negedge clk);
      chk("t4_hold_sum", 32'(rsp_sum), 32'h0BE02);
      chk("t4_hold_id", 32'(rsp_id), 32'd3);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    tick();
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b1;
    @(negedge clk);
    chk("t4_same_cycle", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    repeat (4) tick();

    // Asynchronous reset while in CALC.
    issue(0, 16'h4321, 16'h1234, 1'b0, n);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    set_op(1, 16'h0101, 16'h0202, 1'b0);
    set_op(3, 16'h0303, 16'h0404, 1'b1);
    req_valid = 4'b1010;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_rsp_valid_async", 32'(rsp_valid), 32'd0);
    chk("t5_req_ready_async", 32'(req_ready), 32'd0);
    chk("t5_rsp_sum_async", 32'(rsp_sum), 32'd0);
    @(negedge clk);
    #2;
    req_valid = '0;
    rst       = 1'b0;
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    wait_rsp(m);
    chk("t5_rsp_id", 32'(rsp_id), 32'd1);
    chk("t5_rsp_sum", 32'(rsp_sum), 32'h00303);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if ($urandom % 100 < 35) begin
            set_op(i, rand16(), rand16(), 1'($urandom % 2));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom % 100 < 5) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
